arb_rr8: RTL and testbench

Eight-way round-robin arbiter that shares one downstream resource among eight requesters. Each cycle's winner is presented as a 3-bit index plus an enable. These feed the team's 3-to-8 one-hot decoder (I / E / Q style), which drives per-requester select lines. A matching one-hot grant vector is also provided. Optional hold-time limiting prevents a requester from starving the others.

---
 rtl/arb_rr8.sv | 113 +++++++++++
 tb/tb_arb_rr8.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr8.sv
// Eight-way round-robin arbiter with optional per-tenure hold limit.
// Winner is presented as index + enable for a 3-to-8 decoder, plus a one-hot copy.
module arb_rr8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic       gnt_en,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam bit         HOLD_ON   = (HOLD_MAX != 0);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_en_q, gnt_en_d;
  logic [7:0] gnt_q, gnt_d;
  logic       timeout_q, timeout_d;

  logic [7:0] rot;
  logic [2:0] off;
  logic [2:0] win;
  logic       own_req;
  logic       forced;

  // Rotate so ptr sits at bit 0; the lowest set bit is then the round-robin winner.
  always_comb begin
    rot = 8'({req, req} >> ptr_q);
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    win = ptr_q + off;
  end

  assign own_req = req[gnt_idx_q];
  assign forced  = HOLD_ON && own_req && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_en_d  = gnt_en_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (|req) begin
          state_d   = GRANT;
          gnt_idx_d = win;
          gnt_en_d  = 1'b1;
          gnt_d     = 8'(1) << win;
          cnt_d     = 8'd0;
        end else begin
          state_d  = IDLE;
          gnt_en_d = 1'b0;
          gnt_d    = 8'h00;
        end
      end
      GRANT: begin
        if (!own_req || forced) begin
          state_d   = GAP;
          ptr_d     = gnt_idx_q + 3'd1;
          gnt_en_d  = 1'b0;
          gnt_d     = 8'h00;
          timeout_d = forced;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_en_d = 1'b0;
        gnt_d    = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      cnt_q     <= 8'd0;
      gnt_idx_q <= 3'd0;
      gnt_en_q  <= 1'b0;
      gnt_q     <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_en_q  <= gnt_en_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_en  = gnt_en_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt     = gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb_rr8.sv
// Directed bench for arb_rr8: four instances cover HOLD_MAX of 16, 4, 1 and 0.
// Observed outputs are packed as {gnt_en, gnt_idx, gnt, timeout}.
module tb_arb_rr8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req, req4, req1, req0;
  logic       en16, en4, en1, en0;
  logic [2:0] ix16, ix4, ix1, ix0;
  logic [7:0] g16, g4, g1, g0;
  logic       to16, to4, to1, to0;
  logic [12:0] obs, obs4, obs1, obs0, e;
  int n_cmp, n_err;

  arb_rr8 #(.HOLD_MAX(16)) dut  (.clk(clk), .rst_n(rst_n), .req(req),  .gnt_en(en16), .gnt_idx(ix16), .gnt(g16), .timeout(to16));
  arb_rr8 #(.HOLD_MAX(4))  dut4 (.clk(clk), .rst_n(rst_n), .req(req4), .gnt_en(en4),  .gnt_idx(ix4),  .gnt(g4),  .timeout(to4));
  arb_rr8 #(.HOLD_MAX(1))  dut1 (.clk(clk), .rst_n(rst_n), .req(req1), .gnt_en(en1),  .gnt_idx(ix1),  .gnt(g1),  .timeout(to1));
  arb_rr8 #(.HOLD_MAX(0))  dut0 (.clk(clk), .rst_n(rst_n), .req(req0), .gnt_en(en0),  .gnt_idx(ix0),  .gnt(g0),  .timeout(to0));

  assign obs  = {en16, ix16, g16, to16};
  assign obs4 = {en4,  ix4,  g4,  to4};
  assign obs1 = {en1,  ix1,  g1,  to1};
  assign obs0 = {en0,  ix0,  g0,  to0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 8'h00; req4 = 8'h00; req1 = 8'h00; req0 = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'hFF; req4 = 8'hFF; req1 = 8'hFF; req0 = 8'hFF;
    tick();
    tick();
    n_cmp++; if (obs !== 13'h0)  begin n_err++; $display("FAIL reset_hold16 got=%h want=%h", obs, 13'h0); end
    n_cmp++; if (obs4 !== 13'h0) begin n_err++; $display("FAIL reset_hold4 got=%h want=%h", obs4, 13'h0); end
    req = 8'h00; req4 = 8'h00; req1 = 8'h00; req0 = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (obs !== 13'h0) begin n_err++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, 13'h0); end
    end
  endtask

  task automatic test_single();
    req = 8'h20;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = {1'b1, 3'd5, 8'h20, 1'b0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL single_grant cyc=%0d got=%h want=%h", i, obs, e); end
    end
    req = 8'h00;
    tick();
    e = {1'b0, 3'd5, 8'h00, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL single_gap got=%h want=%h", obs, e); end
    tick();
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL single_idle got=%h want=%h", obs, e); end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      e = {1'b1, 3'(k % 8), 8'(1 << (k % 8)), 1'b0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rot_grant k=%0d got=%h want=%h", k, obs, e); end
      req[k % 8] = 1'b0;
      tick();
      e = {1'b0, 3'(k % 8), 8'h00, 1'b0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rot_gap k=%0d got=%h want=%h", k, obs, e); end
      req = (k == 8) ? 8'h00 : 8'hFF;
    end
    tick();
    e = {1'b0, 3'd0, 8'h00, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL rot_idle got=%h want=%h", obs, e); end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h40;
    tick();
    e = {1'b1, 3'd6, 8'h40, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL wrap_own6 got=%h want=%h", obs, e); end
    req = 8'h05;
    tick();
    e = {1'b0, 3'd6, 8'h00, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL wrap_gap6 got=%h want=%h", obs, e); end
    tick();
    e = {1'b1, 3'd0, 8'h01, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL wrap_own0 got=%h want=%h", obs, e); end
    req = 8'h04;
    tick();
    e = {1'b0, 3'd0, 8'h00, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL wrap_gap0 got=%h want=%h", obs, e); end
    tick();
    e = {1'b1, 3'd2, 8'h04, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL wrap_own2 got=%h want=%h", obs, e); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_hold4();
    do_reset();
    req4 = 8'h0A;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        e = (r == 0) ? {1'b1, 3'd1, 8'h02, 1'b0} : {1'b1, 3'd3, 8'h08, 1'b0};
        n_cmp++; if (obs4 !== e) begin n_err++; $display("FAIL hold4_own r=%0d cyc=%0d got=%h want=%h", r, i, obs4, e); end
      end
      tick();
      e = (r == 0) ? {1'b0, 3'd1, 8'h00, 1'b1} : {1'b0, 3'd3, 8'h00, 1'b1};
      n_cmp++; if (obs4 !== e) begin n_err++; $display("FAIL hold4_timeout r=%0d got=%h want=%h", r, obs4, e); end
    end
    tick();
    e = {1'b1, 3'd1, 8'h02, 1'b0};
    n_cmp++; if (obs4 !== e) begin n_err++; $display("FAIL hold4_back1 got=%h want=%h", obs4, e); end
    req4 = 8'h00;
    tick();
    e = {1'b0, 3'd1, 8'h00, 1'b0};
    n_cmp++; if (obs4 !== e) begin n_err++; $display("FAIL hold4_voluntary got=%h want=%h", obs4, e); end
  endtask

  task automatic test_hold16();
    do_reset();
    req = 8'h03;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = {1'b1, 3'd0, 8'h01, 1'b0};
      n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hold16_own cyc=%0d got=%h want=%h", i, obs, e); end
    end
    tick();
    e = {1'b0, 3'd0, 8'h00, 1'b1};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hold16_timeout got=%h want=%h", obs, e); end
    tick();
    e = {1'b1, 3'd1, 8'h02, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL hold16_next got=%h want=%h", obs, e); end
    req = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req1 = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      e = {1'b1, 3'(k % 8), 8'(1 << (k % 8)), 1'b0};
      n_cmp++; if (obs1 !== e) begin n_err++; $display("FAIL b2b_grant k=%0d got=%h want=%h", k, obs1, e); end
      tick();
      e = {1'b0, 3'(k % 8), 8'h00, 1'b1};
      n_cmp++; if (obs1 !== e) begin n_err++; $display("FAIL b2b_gap k=%0d got=%h want=%h", k, obs1, e); end
    end
    req1 = 8'h00;
    tick();
  endtask

  task automatic test_unlimited();
    do_reset();
    req0 = 8'h03;
    for (int i = 0; i < 300; i++) begin
      tick();
      e = {1'b1, 3'd0, 8'h01, 1'b0};
      n_cmp++; if (obs0 !== e) begin n_err++; $display("FAIL unlim_own cyc=%0d got=%h want=%h", i, obs0, e); end
    end
    req0 = 8'h02;
    tick();
    e = {1'b0, 3'd0, 8'h00, 1'b0};
    n_cmp++; if (obs0 !== e) begin n_err++; $display("FAIL unlim_release got=%h want=%h", obs0, e); end
    tick();
    e = {1'b1, 3'd1, 8'h02, 1'b0};
    n_cmp++; if (obs0 !== e) begin n_err++; $display("FAIL unlim_next got=%h want=%h", obs0, e); end
    req0 = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h10;
    tick();
    e = {1'b1, 3'd4, 8'h10, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL arst_own4 got=%h want=%h", obs, e); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (obs !== 13'h0) begin n_err++; $display("FAIL arst_immediate got=%h want=%h", obs, 13'h0); end
    req = 8'h11;
    tick();
    n_cmp++; if (obs !== 13'h0) begin n_err++; $display("FAIL arst_held got=%h want=%h", obs, 13'h0); end
    rst_n = 1'b1;
    tick();
    e = {1'b1, 3'd0, 8'h01, 1'b0};
    n_cmp++; if (obs !== e) begin n_err++; $display("FAIL arst_restart got=%h want=%h", obs, e); end
    req = 8'h00;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_hold4();
    test_hold16();
    test_back_to_back();
    test_unlimited();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
